uart_rx_monitor: RTL and testbench

//  Parametrised UART receive monitor for the chip testbench and on-chip debug taps.

---
 rtl/uart_rx_monitor.sv | 242 ++++++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: UART receive monitor. Synchronises the serial line,
// deserialises frames of configurable format and buffers them in a
// show-ahead FIFO. Parity, framing, break and overrun conditions are reported.
//
// Output stream handshake: rx_valid is high whenever the FIFO holds at least
// one entry, and rx_data/rx_perr/rx_ferr then show the head entry. The head is
// popped on a rising clk edge where rx_valid & rx_ready are both high.
// rx_valid never depends on rx_ready.
module uart_rx_monitor #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUDRATE   = 25000000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            uart_rx,
  output logic [DATA_BITS-1:0]            rx_data,
  output logic                            rx_perr,
  output logic                            rx_ferr,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  output logic                            overrun,
  output logic                            break_det,
  output logic [15:0]                     frame_cnt,
  output logic [2:0]                      o_dbg_state
);

  localparam int DIV  = CLK_HZ / BAUDRATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = $clog2(FIFO_DEPTH + 1);
  localparam int FW   = DATA_BITS + 2;

  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchroniser
  logic r_sync1;
  logic r_sync2;
  logic w_rxs;

  // Receiver
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [IW-1:0]        r_idx;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_par_bit;
  logic                 r_stop_idx;
  logic                 r_stop0_low;
  logic                 r_break_det;

  // FIFO
  logic [FW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [15:0]   r_frame_cnt;
  logic          r_overrun;

  logic          w_tick;
  logic          w_last_stop;
  logic          w_push;
  logic          w_push_ferr;
  logic          w_first_stop_low;
  logic          w_break;
  logic [FW-1:0] w_push_word;
  logic          w_pop;
  logic          w_full;
  logic          w_wr;
  logic [FW-1:0] w_head;

  // Two-flop line synchroniser; resets to the idle (high) level
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs       = r_sync2;
  assign w_tick      = (r_cnt == '0);
  assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_idx;
  assign w_push      = (r_state == S_STOP) && w_tick && w_last_stop;
  assign w_push_ferr = r_ferr | ~w_rxs;
  assign w_push_word = {w_push_ferr, r_perr, r_data};

  // A break needs the first stop bit low; with one stop bit that is the
  // sample being taken right now.
  assign w_first_stop_low = r_stop_idx ? r_stop0_low : ~w_rxs;
  assign w_break = w_push && (r_data == '0) &&
                   ((PARITY == 0) || !r_par_bit) && w_first_stop_low;

  // Receive FSM: bit timing, deserialisation, error capture, break pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_data      <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_par_bit   <= 1'b0;
      r_stop_idx  <= 1'b0;
      r_stop0_low <= 1'b0;
      r_break_det <= 1'b0;
    end else begin
      r_break_det <= w_break;
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            r_cnt   <= CNT_HALF;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (w_rxs) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt       <= CNT_FULL;
              r_idx       <= '0;
              r_perr      <= 1'b0;
              r_ferr      <= 1'b0;
              r_par_bit   <= 1'b0;
              r_stop_idx  <= 1'b0;
              r_stop0_low <= 1'b0;
              r_state     <= S_DATA;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_data[r_idx] <= w_rxs;
            r_cnt         <= CNT_FULL;
            if (r_idx == LAST_BIT) begin
              r_state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_perr    <= (((^r_data) ^ w_rxs) != (PARITY == 1));
            r_par_bit <= w_rxs;
            r_cnt     <= CNT_FULL;
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (w_last_stop) begin
              // Frame is pushed this cycle; return without waiting out the stop bit
              r_state <= S_IDLE;
            end else begin
              r_ferr      <= w_push_ferr;
              r_stop0_low <= ~w_rxs;
              r_stop_idx  <= 1'b1;
              r_cnt       <= CNT_FULL;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop  = rx_valid & rx_ready;
  assign w_full = (r_level == LVL_FULL);
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign w_wr   = w_push & (~w_full | w_pop);

  // Receive FIFO: storage, pointers, exact level, frame counter, overrun pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_frame_cnt <= '0;
      r_overrun   <= 1'b0;
    end else begin
      r_overrun <= w_push & w_full & ~w_pop;
      if (w_wr) begin
        r_mem[r_wptr] <= w_push_word;
        r_wptr        <= r_wptr + AW'(1);
        r_frame_cnt   <= r_frame_cnt + 16'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign w_head      = r_mem[r_rptr];
  assign rx_valid    = (r_level != '0);
  assign rx_data     = w_head[DATA_BITS-1:0];
  assign rx_perr     = w_head[DATA_BITS];
  assign rx_ferr     = w_head[DATA_BITS+1];
  assign fifo_level  = r_level;
  assign overrun     = r_overrun;
  assign break_det   = r_break_det;
  assign frame_cnt   = r_frame_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: directed bench for uart_rx_monitor. Three instances:
// 8N1 at DIV = 2, 8E1 at DIV = 2, and 8N1 at DIV = 8.
module tb_uart_rx_monitor;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic       line_a, line_p, line_s;
  logic       rdy_a, rdy_p, rdy_s;
  logic [7:0] data_a, data_p, data_s;
  logic       perr_a, perr_p, perr_s;
  logic       ferr_a, ferr_p, ferr_s;
  logic       valid_a, valid_p, valid_s;
  logic [4:0] level_a, level_p, level_s;
  logic       ovr_a, ovr_p, ovr_s;
  logic       brk_a, brk_p, brk_s;
  logic [15:0] fcnt_a, fcnt_p, fcnt_s;
  logic [2:0] st_a, st_p, st_s;

  uart_rx_monitor u_dut (
    .clk(clk), .resetn(resetn), .uart_rx(line_a),
    .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_valid(valid_a),
    .rx_ready(rdy_a), .fifo_level(level_a), .overrun(ovr_a), .break_det(brk_a),
    .frame_cnt(fcnt_a), .o_dbg_state(st_a)
  );

  uart_rx_monitor #(.PARITY(2)) u_par (
    .clk(clk), .resetn(resetn), .uart_rx(line_p),
    .rx_data(data_p), .rx_perr(perr_p), .rx_ferr(ferr_p), .rx_valid(valid_p),
    .rx_ready(rdy_p), .fifo_level(level_p), .overrun(ovr_p), .break_det(brk_p),
    .frame_cnt(fcnt_p), .o_dbg_state(st_p)
  );

  uart_rx_monitor #(.BAUDRATE(6250000)) u_slow (
    .clk(clk), .resetn(resetn), .uart_rx(line_s),
    .rx_data(data_s), .rx_perr(perr_s), .rx_ferr(ferr_s), .rx_valid(valid_s),
    .rx_ready(rdy_s), .fifo_level(level_s), .overrun(ovr_s), .break_det(brk_s),
    .frame_cnt(fcnt_s), .o_dbg_state(st_s)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0] exp_q[$];
  logic [9:0] exp_q_p[$];
  logic [9:0] exp_q_s[$];
  logic [9:0] got_a[$];
  logic [9:0] got_p[$];
  logic [9:0] got_s[$];
  int n_checks;
  int n_fail;
  int vcyc_a, vcyc_s, novr_a, nbrk_a, nbrk_p;
  logic clr_mon;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (clr_mon) begin
      got_a.delete(); got_p.delete(); got_s.delete();
      vcyc_a = 0; vcyc_s = 0; novr_a = 0; nbrk_a = 0; nbrk_p = 0;
    end else begin
      if (valid_a && rdy_a) got_a.push_back({ferr_a, perr_a, data_a});
      if (valid_p && rdy_p) got_p.push_back({ferr_p, perr_p, data_p});
      if (valid_s && rdy_s) got_s.push_back({ferr_s, perr_s, data_s});
      if (valid_a) vcyc_a++;
      if (valid_s) vcyc_s++;
      if (ovr_a) novr_a++;
      if (brk_a) nbrk_a++;
      if (brk_p) nbrk_p++;
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input int sel, input string tag);
    logic [9:0] e[$];
    logic [9:0] g[$];
    case (sel)
      0:       begin e = exp_q;   g = got_a; end
      1:       begin e = exp_q_p; g = got_p; end
      default: begin e = exp_q_s; g = got_s; end
    endcase
    check_eq({tag, "_count"}, g.size(), e.size());
    for (int i = 0; i < e.size(); i++) begin
      if (i < g.size()) check_eq($sformatf("%s_%0d", tag, i), {22'd0, g[i]}, {22'd0, e[i]});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       line_a = v;
      1:       line_p = v;
      default: line_s = v;
    endcase
  endtask

  task automatic drive_bit(input int sel, input int div, input logic b);
    set_line(sel, b);
    idle(div);
  endtask

  task automatic send_frame(input int sel, input int div, input logic [7:0] data,
                            input bit has_par, input logic par_bit, input logic stop_bit);
    drive_bit(sel, div, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, div, data[i]);
    if (has_par) drive_bit(sel, div, par_bit);
    drive_bit(sel, div, stop_bit);
    set_line(sel, 1'b1);
  endtask

  task automatic do_reset();
    clr_mon = 1'b1;
    resetn  = 1'b0;
    line_a = 1'b1; line_p = 1'b1; line_s = 1'b1;
    rdy_a = 1'b0; rdy_p = 1'b0; rdy_s = 1'b0;
    exp_q.delete(); exp_q_p.delete(); exp_q_s.delete();
    idle(2);
    resetn = 1'b1;
    idle(1);
    clr_mon = 1'b0;
    idle(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    do_reset();

    // Reset state
    check_eq("rst_valid", valid_a, 1'b0);
    check_eq("rst_level", level_a, 5'd0);
    check_eq("rst_fcnt", fcnt_a, 16'd0);
    check_eq("rst_ovr", ovr_a, 1'b0);
    check_eq("rst_brk", brk_a, 1'b0);
    check_eq("rst_data", data_a, 8'h00);
    check_eq("rst_state", st_a, 3'd0);
    check_eq("rst_valid_p", valid_p, 1'b0);
    check_eq("rst_valid_s", valid_s, 1'b0);

    // Single 0xA5 frame with the consumer always ready
    rdy_a = 1'b1;
    send_frame(0, 2, 8'hA5, 1'b0, 1'b0, 1'b1);
    exp_q.push_back({2'b00, 8'hA5});
    idle(8);
    sb_check(0, "a5");
    check_eq("a5_valid_cycles", vcyc_a, 1);
    check_eq("a5_fcnt", fcnt_a, 16'd1);
    check_eq("a5_level", level_a, 5'd0);

    // 17 back-to-back frames into a stalled FIFO
    do_reset();
    for (int i = 0; i < 17; i++) send_frame(0, 2, 8'(i), 1'b0, 1'b0, 1'b1);
    idle(6);
    check_eq("ovf_level", level_a, 5'd16);
    check_eq("ovf_pulses", novr_a, 1);
    check_eq("ovf_fcnt", fcnt_a, 16'd16);
    rdy_a = 1'b1;
    idle(24);
    for (int i = 0; i < 16; i++) exp_q.push_back({2'b00, 8'(i)});
    sb_check(0, "ovf_drain");
    check_eq("ovf_drain_level", level_a, 5'd0);
    check_eq("ovf_drain_fcnt", fcnt_a, 16'd16);

    // Full FIFO, pop coinciding with a push
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(0, 2, 8'(i), 1'b0, 1'b0, 1'b1);
    idle(4);
    check_eq("full_level", level_a, 5'd16);
    fork
      send_frame(0, 2, 8'h77, 1'b0, 1'b0, 1'b1);
      begin
        idle(21);
        rdy_a = 1'b1;
        idle(1);
        rdy_a = 1'b0;
      end
    join
    idle(6);
    check_eq("full_pp_level", level_a, 5'd16);
    check_eq("full_pp_ovr", novr_a, 0);
    check_eq("full_pp_fcnt", fcnt_a, 16'd17);
    rdy_a = 1'b1;
    idle(24);
    for (int i = 0; i < 16; i++) exp_q.push_back({2'b00, 8'(i)});
    exp_q.push_back({2'b00, 8'h77});
    sb_check(0, "full_pp_drain");

    // Even parity: 0x03 with wrong then right parity bit
    do_reset();
    rdy_p = 1'b1;
    send_frame(1, 2, 8'h03, 1'b1, 1'b1, 1'b1);
    send_frame(1, 2, 8'h03, 1'b1, 1'b0, 1'b1);
    exp_q_p.push_back({2'b01, 8'h03});
    exp_q_p.push_back({2'b00, 8'h03});
    idle(8);
    sb_check(1, "par");
    check_eq("par_fcnt", fcnt_p, 16'd2);
    check_eq("par_brk", nbrk_p, 0);

    // Framing error, then break
    do_reset();
    rdy_a = 1'b1;
    send_frame(0, 2, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle(8);
    check_eq("ferr_brk", nbrk_a, 0);
    send_frame(0, 2, 8'h00, 1'b0, 1'b0, 1'b0);
    idle(8);
    exp_q.push_back({2'b10, 8'h5A});
    exp_q.push_back({2'b10, 8'h00});
    sb_check(0, "ferr");
    check_eq("brk_pulses", nbrk_a, 1);
    check_eq("brk_fcnt", fcnt_a, 16'd2);

    // One-clock low glitch at DIV = 8, then a clean frame
    do_reset();
    rdy_s = 1'b1;
    set_line(2, 1'b0);
    idle(1);
    set_line(2, 1'b1);
    idle(40);
    check_eq("glitch_valid", vcyc_s, 0);
    check_eq("glitch_fcnt", fcnt_s, 16'd0);
    send_frame(2, 8, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(12);
    exp_q_s.push_back({2'b00, 8'h3C});
    sb_check(2, "slow");

    // Reset in the middle of the data bits, then a clean 0x3C
    do_reset();
    drive_bit(0, 2, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 2, 1'b1);
    do_reset();
    check_eq("midrst_level", level_a, 5'd0);
    rdy_a = 1'b1;
    send_frame(0, 2, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(8);
    exp_q.push_back({2'b00, 8'h3C});
    sb_check(0, "midrst");
    check_eq("midrst_fcnt", fcnt_a, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
